// File: rtl/mips_pkg.sv
// Shared MIPS decode constants for the ID/EX immediate path.
// Opcode/funct encodings and the immediate-select enum.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;

   typedef enum logic [1:0] {
      IMM_SEXT,
      IMM_ZEXT,
      IMM_LUI
   } imm_sel_e;

endpackage

// File: rtl/id_ex_imm_stage_if.sv
// ID-side inputs and ID/EX slot outputs of the immediate stage.
// slave = the stage itself, master = whoever drives ID.
interface id_ex_imm_stage_if #(
   parameter int STALL_CNT_W = 16
);
   logic                   IF_ID_valid;
   logic [31:0]            IF_ID_instr;
   logic                   EX_flush;
   logic                   stall_out;
   logic                   ID_EX_valid;
   logic [31:0]            ID_EX_imm;
   logic [31:0]            ID_EX_lui_imm;
   logic [4:0]             ID_EX_shamt;
   logic [4:0]             ID_EX_rs;
   logic [4:0]             ID_EX_rt;
   logic [4:0]             ID_EX_rd;
   logic                   ID_EX_is_lui;
   logic                   ID_EX_mem_read;
   logic [STALL_CNT_W-1:0] stall_count;

   modport master (
      output IF_ID_valid, IF_ID_instr, EX_flush,
      input  stall_out, ID_EX_valid, ID_EX_imm,
      input  ID_EX_lui_imm, ID_EX_shamt, ID_EX_rs,
      input  ID_EX_rt, ID_EX_rd, ID_EX_is_lui,
      input  ID_EX_mem_read, stall_count
   );

   modport slave (
      input  IF_ID_valid, IF_ID_instr, EX_flush,
      output stall_out, ID_EX_valid, ID_EX_imm,
      output ID_EX_lui_imm, ID_EX_shamt, ID_EX_rs,
      output ID_EX_rt, ID_EX_rd, ID_EX_is_lui,
      output ID_EX_mem_read, stall_count
   );
endinterface

// File: rtl/imm_gen.sv
// Combinational immediate extraction from a MIPS instruction word.
// Produces every immediate variant plus the operand select.
module imm_gen
   import mips_pkg::*;
#(
   parameter int LUI_SHIFT = 16
) (
   input  logic [31:0] i_instr,
   output logic [31:0] o_sext,
   output logic [31:0] o_zext,
   output logic [31:0] o_lui_imm,
   output logic [4:0]  o_shamt,
   output imm_sel_e    o_imm_sel
);
   logic [15:0] w_imm16;
   logic [5:0]  w_op;

   assign w_imm16   = i_instr[15:0];
   assign w_op      = i_instr[31:26];
   assign o_sext    = {{16{w_imm16[15]}}, w_imm16};
   assign o_zext    = {16'h0000, w_imm16};
   assign o_lui_imm = o_zext << LUI_SHIFT;
   assign o_shamt   = i_instr[10:6];

   always_comb begin
      o_imm_sel = IMM_SEXT;
      unique case (1'b1)
         (w_op == OP_LUI): o_imm_sel = IMM_LUI;
         (w_op == OP_ANDI),
         (w_op == OP_ORI),
         (w_op == OP_XORI): o_imm_sel = IMM_ZEXT;
         default: o_imm_sel = IMM_SEXT;
      endcase
   end
endmodule

// File: rtl/id_ex_imm_stage.sv
// ID/EX boundary: immediate select, load-use hazard, ID/EX slot.
// Bubbles clear mem_read, so a load-use stall lasts one cycle.
module id_ex_imm_stage
   import mips_pkg::*;
#(
   parameter int LUI_SHIFT   = 16,
   parameter int STALL_CNT_W = 16
) (
   input logic Clock,
   input logic Reset,
   input logic Tick,
   id_ex_imm_stage_if.slave bus
);
   logic [5:0]  w_op;
   logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
   logic [31:0] w_sext, w_zext, w_lui, w_imm;
   imm_sel_e    w_sel;
   logic        w_uses_rs, w_uses_rt, w_hazard;

   logic                   r_valid, r_is_lui, r_mem_read;
   logic [31:0]            r_imm, r_lui;
   logic [4:0]             r_shamt, r_rs, r_rt, r_rd;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   imm_gen #(.LUI_SHIFT(LUI_SHIFT)) u_imm_gen (
      .i_instr   (bus.IF_ID_instr),
      .o_sext    (w_sext),
      .o_zext    (w_zext),
      .o_lui_imm (w_lui),
      .o_shamt   (w_shamt),
      .o_imm_sel (w_sel)
   );

   assign w_op = bus.IF_ID_instr[31:26];
   assign w_rs = bus.IF_ID_instr[25:21];
   assign w_rt = bus.IF_ID_instr[20:16];
   assign w_rd = bus.IF_ID_instr[15:11];

   always_comb begin
      w_imm = w_sext;
      unique case (w_sel)
         IMM_LUI:  w_imm = w_lui;
         IMM_ZEXT: w_imm = w_zext;
         default:  w_imm = w_sext;
      endcase
   end

   // shifts count as rs users: conservative, costs only extra stalls
   assign w_uses_rs = !(w_op inside {OP_LUI, OP_J, OP_JAL});
   assign w_uses_rt = w_op inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE};

   assign w_hazard = bus.IF_ID_valid & r_valid & r_mem_read
                   & (r_rt != 5'd0)
                   & ((w_uses_rs & (w_rs == r_rt))
                    | (w_uses_rt & (w_rt == r_rt)));

   assign bus.stall_out = w_hazard & ~bus.EX_flush & Reset;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_valid     <= 1'b0;
         r_is_lui    <= 1'b0;
         r_mem_read  <= 1'b0;
         r_imm       <= '0;
         r_lui       <= '0;
         r_shamt     <= '0;
         r_rs        <= '0;
         r_rt        <= '0;
         r_rd        <= '0;
         r_stall_cnt <= '0;
      end else if (Tick) begin
         if (bus.EX_flush) begin
            r_valid    <= 1'b0;
            r_is_lui   <= 1'b0;
            r_mem_read <= 1'b0;
         end else if (w_hazard) begin
            r_valid    <= 1'b0;
            r_is_lui   <= 1'b0;
            r_mem_read <= 1'b0;
            if (!(&r_stall_cnt))
               r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
         end else begin
            r_valid    <= bus.IF_ID_valid;
            r_is_lui   <= bus.IF_ID_valid & (w_op == OP_LUI);
            r_mem_read <= bus.IF_ID_valid & (w_op == OP_LW);
            r_imm      <= w_imm;
            r_lui      <= w_lui;
            r_shamt    <= w_shamt;
            r_rs       <= w_rs;
            r_rt       <= w_rt;
            r_rd       <= w_rd;
         end
      end
   end

   assign bus.ID_EX_valid    = r_valid;
   assign bus.ID_EX_imm      = r_imm;
   assign bus.ID_EX_lui_imm  = r_lui;
   assign bus.ID_EX_shamt    = r_shamt;
   assign bus.ID_EX_rs       = r_rs;
   assign bus.ID_EX_rt       = r_rt;
   assign bus.ID_EX_rd       = r_rd;
   assign bus.ID_EX_is_lui   = r_is_lui;
   assign bus.ID_EX_mem_read = r_mem_read;
   assign bus.stall_count    = r_stall_cnt;
endmodule

// File: tb/tb_id_ex_imm_stage.sv
// Scoreboard bench for id_ex_imm_stage (16-bit and 2-bit counters).
// Stimulus pushes hand-computed expectations; a monitor pops them.
module tb_id_ex_imm_stage;

   localparam logic [31:0] I_LUI   = 32'h3C081234;
   localparam logic [31:0] I_ORI   = 32'h3508FFFF;
   localparam logic [31:0] I_ADDI1 = 32'h2108FFFF;
   localparam logic [31:0] I_ADDI2 = 32'h21088000;
   localparam logic [31:0] I_LW    = 32'h8D080000;
   localparam logic [31:0] I_ADD   = 32'h010A4820;
   localparam logic [31:0] I_LWZ   = 32'h8D000000;
   localparam logic [31:0] I_ADDZ  = 32'h00004820;

   typedef struct {
      bit          pre;
      int          lvl;
      logic [31:0] stall, valid, is_lui, mr, cnt, cnt2;
      logic [31:0] imm, lui, sh, rs, rt, rd;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic tick;
   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   id_ex_imm_stage_if #(.STALL_CNT_W(16)) bus ();
   id_ex_imm_stage_if #(.STALL_CNT_W(2))  bus2 ();

   id_ex_imm_stage #(.LUI_SHIFT(16), .STALL_CNT_W(16)) dut (
      .Clock (clk),
      .Reset (rst_n),
      .Tick  (tick),
      .bus   (bus)
   );

   id_ex_imm_stage #(.LUI_SHIFT(16), .STALL_CNT_W(2)) dut2 (
      .Clock (clk),
      .Reset (rst_n),
      .Tick  (tick),
      .bus   (bus2)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic exp_t ex(
      logic [31:0] stall, valid, is_lui, mr, cnt, cnt2,
      int lvl,
      logic [31:0] imm = 0, lui = 0,
      logic [31:0] sh = 0, rs = 0, rt = 0, rd = 0);
      exp_t e;
      e.pre = 1'b0; e.lvl = lvl;
      e.stall = stall; e.valid = valid;
      e.is_lui = is_lui; e.mr = mr;
      e.cnt = cnt; e.cnt2 = cnt2;
      e.imm = imm; e.lui = lui;
      e.sh = sh; e.rs = rs; e.rt = rt; e.rd = rd;
      return e;
   endfunction

   function automatic exp_t lw_e(logic [31:0] c, c2);
      return ex(0, 1, 0, 1, c, c2, 2, 0, 0, 0, 8, 8, 0);
   endfunction

   function automatic exp_t add_e(logic [31:0] c, c2);
      return ex(0, 1, 0, 0, c, c2, 2,
                32'h00004820, 32'h48200000, 0, 8, 10, 9);
   endfunction

   task automatic step(bit rn, bit v, logic [31:0] ins,
                       bit fl, bit tk, exp_t e);
      @(negedge clk);
      #1;
      rst_n = rn;
      tick  = tk;
      bus.IF_ID_valid  = v;
      bus.IF_ID_instr  = ins;
      bus.EX_flush     = fl;
      bus2.IF_ID_valid = v;
      bus2.IF_ID_instr = ins;
      bus2.EX_flush    = fl;
      q.push_back(e);
   endtask

   // monitor: stall_out just before the edge, registers just after
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("stall_out", 32'(bus.stall_out), e.stall);
            chk("stall_out_w2", 32'(bus2.stall_out), e.stall);
            if (!e.pre) begin
               @(posedge clk);
               #1;
            end
            chk("valid", 32'(bus.ID_EX_valid), e.valid);
            chk("valid_w2", 32'(bus2.ID_EX_valid), e.valid);
            chk("stall_count", 32'(bus.stall_count), e.cnt);
            chk("stall_count_w2", 32'(bus2.stall_count), e.cnt2);
            if (e.lvl >= 1) begin
               chk("is_lui", 32'(bus.ID_EX_is_lui), e.is_lui);
               chk("mem_read", 32'(bus.ID_EX_mem_read), e.mr);
            end
            if (e.lvl >= 2) begin
               chk("imm", bus.ID_EX_imm, e.imm);
               chk("lui_imm", bus.ID_EX_lui_imm, e.lui);
               chk("shamt", 32'(bus.ID_EX_shamt), e.sh);
               chk("rs", 32'(bus.ID_EX_rs), e.rs);
               chk("rt", 32'(bus.ID_EX_rt), e.rt);
               chk("rd", 32'(bus.ID_EX_rd), e.rd);
            end
         end
      end
   end

   initial begin
      exp_t e;
      rst_n = 1'b0;
      tick  = 1'b1;
      bus.IF_ID_valid  = 1'b0;
      bus.IF_ID_instr  = '0;
      bus.EX_flush     = 1'b0;
      bus2.IF_ID_valid = 1'b0;
      bus2.IF_ID_instr = '0;
      bus2.EX_flush    = 1'b0;

      repeat (3) step(0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 2));
      step(1, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 2));

      step(1, 1, I_LUI, 0, 1, ex(0, 1, 1, 0, 0, 0, 2,
           32'h12340000, 32'h12340000, 8, 0, 8, 2));
      step(1, 1, I_ORI, 0, 1, ex(0, 1, 0, 0, 0, 0, 2,
           32'h0000FFFF, 32'hFFFF0000, 31, 8, 8, 31));
      step(1, 1, I_ADDI1, 0, 1, ex(0, 1, 0, 0, 0, 0, 2,
           32'hFFFFFFFF, 32'hFFFF0000, 31, 8, 8, 31));
      step(1, 1, I_ADDI2, 0, 1, ex(0, 1, 0, 0, 0, 0, 2,
           32'hFFFF8000, 32'h80000000, 0, 8, 8, 16));

      step(1, 1, I_LW, 0, 1, lw_e(0, 0));
      step(1, 1, I_ADD, 0, 1, ex(1, 0, 0, 0, 1, 1, 1));
      step(1, 1, I_ADD, 0, 1, add_e(1, 1));

      step(1, 1, I_LWZ, 0, 1, ex(0, 1, 0, 1, 1, 1, 2,
           0, 0, 0, 8, 0, 0));
      step(1, 1, I_ADDZ, 0, 1, ex(0, 1, 0, 0, 1, 1, 2,
           32'h00004820, 32'h48200000, 0, 0, 0, 9));

      step(1, 1, I_LW, 0, 1, lw_e(1, 1));
      step(1, 1, I_ADD, 1, 1, ex(0, 0, 0, 0, 1, 1, 0));
      step(1, 1, I_ADD, 0, 1, add_e(1, 1));

      step(1, 1, I_LW, 0, 1, lw_e(1, 1));
      e = lw_e(1, 1);
      e.stall = 1;
      repeat (5) step(1, 1, I_ADD, 0, 0, e);
      step(1, 1, I_ADD, 0, 1, ex(1, 0, 0, 0, 2, 2, 1));
      step(1, 1, I_ADD, 0, 1, add_e(2, 2));

      for (int k = 0; k < 3; k++) begin
         step(1, 1, I_LW, 0, 1, lw_e(2 + k, (k == 0) ? 2 : 3));
         step(1, 1, I_ADD, 0, 1, ex(1, 0, 0, 0, 3 + k, 3, 1));
         step(1, 1, I_ADD, 0, 1, add_e(3 + k, 3));
      end

      step(1, 1, I_LW, 0, 1, lw_e(5, 3));
      e = lw_e(5, 3);
      e.stall = 1;
      step(1, 1, I_ADD, 0, 0, e);
      e = ex(0, 0, 0, 0, 0, 0, 2);
      e.pre = 1'b1;
      step(0, 1, I_ADD, 0, 1, e);
      step(1, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 2));

      for (int i = 0; i < 20 && q.size() != 0; i++)
         @(posedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0",
                  q.size());
      end
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
